// File: rtl/usb_boot_pkg.sv
// Shared definitions for the USB boot sequencer: state encoding,
// counter widths and the default timing constants at 48 MHz.
package usb_boot_pkg;

    // Shared dwell counter and TX quiet counter widths.
    localparam int DWELL_W = 20;
    localparam int QUIET_W = 8;

    // Default timing, in clk_48mhz cycles.
    localparam int DEF_TX_QUIET_CYCLES = 64;      // bus idle before detach
    localparam int DEF_DRAIN_TIMEOUT   = 48000;   // 1 ms forced-detach limit
    localparam int DEF_DETACH_CYCLES   = 480000;  // 10 ms pull-up-off dwell
    localparam int DEF_SETUP_CYCLES    = 16;      // image-select setup

    // Sequencer states, binary encoded.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_DETACH = 3'd2,
        ST_ARM    = 3'd3,
        ST_BOOT   = 3'd4
    } boot_state_t;

endpackage

// File: rtl/usb_boot_sequencer.sv
// USB detach / warm-boot sequencer. On a boot request it waits for the
// USB transmitter to go quiet (or a drain timeout), drops the D+ pull-up
// for the detach time, presents the captured image select for a setup
// time and then fires the warm-boot trigger, which holds until reset.
// boot_req is a level that is only sampled in IDLE; once the sequence
// starts there is no abort path. dbg_state mirrors the current state.
module usb_boot_sequencer
    import usb_boot_pkg::*;
#(
    parameter int TX_QUIET_CYCLES = DEF_TX_QUIET_CYCLES,
    parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
    parameter int DETACH_CYCLES   = DEF_DETACH_CYCLES,
    parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       boot_req,
    input  logic [1:0] image_sel,
    input  logic       usb_tx_en,
    output logic       usb_pullup_en,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // Counters start at 0 on state entry, so a dwell of N cycles ends
    // when the counter holds N-1.
    localparam logic [DWELL_W-1:0] DRAIN_LAST  = DWELL_W'(DRAIN_TIMEOUT - 1);
    localparam logic [DWELL_W-1:0] DETACH_LAST = DWELL_W'(DETACH_CYCLES - 1);
    localparam logic [DWELL_W-1:0] SETUP_LAST  = DWELL_W'(SETUP_CYCLES - 1);
    localparam logic [QUIET_W-1:0] QUIET_LAST  = QUIET_W'(TX_QUIET_CYCLES - 1);

    if (TX_QUIET_CYCLES < 1 || TX_QUIET_CYCLES > 255 ||
        DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 1048575 ||
        DETACH_CYCLES < 1 || DETACH_CYCLES > 1048575 ||
        SETUP_CYCLES < 1 || SETUP_CYCLES > 1048575) begin : g_bad_params
        $error("usb_boot_sequencer: timing parameter out of range");
    end

    boot_state_t        state_q;
    boot_state_t        state_d;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [QUIET_W-1:0] quiet_cnt;
    logic [1:0]         img_q;
    logic               drain_quiet;
    logic               drain_timeout;
    logic               pullup_d;
    logic [1:0]         wb_sel_d;
    logic               wb_boot_d;
    logic               busy_d;

    // A quiet exit needs this cycle to be idle too, so the count reaching
    // TX_QUIET_CYCLES and the transition coincide.
    assign drain_quiet   = !usb_tx_en && (quiet_cnt >= QUIET_LAST);
    assign drain_timeout = (dwell_cnt >= DRAIN_LAST);
    assign dbg_state     = state_q;

    // State register.
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dwell counter, TX quiet counter and image capture.
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            dwell_cnt <= '0;
            quiet_cnt <= '0;
            img_q     <= '0;
        end else begin
            if (state_d != state_q) begin
                dwell_cnt <= '0;
            end else if (dwell_cnt != '1) begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end

            if (state_q != ST_DRAIN || usb_tx_en) begin
                quiet_cnt <= '0;
            end else if (quiet_cnt != '1) begin
                quiet_cnt <= quiet_cnt + QUIET_W'(1);
            end

            if (state_q == ST_IDLE && boot_req) begin
                img_q <= image_sel;
            end
        end
    end

    // Next-state logic; both DRAIN exits share a single transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (boot_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_quiet || drain_timeout) state_d = ST_DETACH;
            ST_DETACH: if (dwell_cnt >= DETACH_LAST) state_d = ST_ARM;
            ST_ARM:    if (dwell_cnt >= SETUP_LAST) state_d = ST_BOOT;
            ST_BOOT:   state_d = ST_BOOT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs track the state.
    always_comb begin
        pullup_d  = 1'b1;
        wb_sel_d  = 2'b00;
        wb_boot_d = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        case (state_d)
            ST_DETACH: begin
                pullup_d = 1'b0;
            end
            ST_ARM: begin
                pullup_d = 1'b0;
                wb_sel_d = img_q;
            end
            ST_BOOT: begin
                pullup_d  = 1'b0;
                wb_sel_d  = img_q;
                wb_boot_d = 1'b1;
            end
            default: begin
                pullup_d = 1'b1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            usb_pullup_en <= 1'b1;
            wb_s1         <= 1'b0;
            wb_s0         <= 1'b0;
            wb_boot       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            usb_pullup_en <= pullup_d;
            wb_s1         <= wb_sel_d[1];
            wb_s0         <= wb_sel_d[0];
            wb_boot       <= wb_boot_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: doc/usb_boot_sequencer.md
USB_BOOT_SEQUENCER -- requirements
Module: usb_boot_sequencer

Interface
REQ-001 SHALL have parameter TX_QUIET_CYCLES, default 64: consecutive idle cycles of usb_tx_en needed before detach.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 48000: maximum DRAIN dwell (1 ms), after which detach is forced.
REQ-003 SHALL have parameter DETACH_CYCLES, default 480000: pull-up-off dwell before boot (10 ms).
REQ-004 SHALL have parameter SETUP_CYCLES, default 16: image-select setup time before the boot strobe.
REQ-005 SHALL have input clk_48mhz, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have input reset_n, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have input boot_req, 1 bit: level request, driven from host-presence timeout OR boot_to_user_design.
REQ-008 SHALL have input image_sel, 2 bits: warm-boot image index.
REQ-009 SHALL have input usb_tx_en, 1 bit: USB transmitter active, from the protocol engine.
REQ-010 SHALL have output usb_pullup_en, 1 bit: D+ 1.5k pull-up enable.
REQ-011 SHALL have output wb_s1 and wb_s0, 1 bit each: warm-boot image select.
REQ-012 SHALL have output wb_boot, 1 bit: warm-boot trigger.
REQ-013 SHALL have output busy, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement the one-hot-free encoded FSM IDLE -> DRAIN -> DETACH -> ARM -> BOOT; BOOT is terminal until reset.
REQ-015 SHALL, in IDLE, sample boot_req every cycle; boot_req=1 moves to DRAIN next cycle and captures image_sel into a register.
REQ-016 SHALL ignore image_sel changes after capture.
REQ-017 SHALL ignore boot_req deassertion after leaving IDLE; there is no abort.
REQ-018 SHALL, in DRAIN, count consecutive cycles with usb_tx_en=0; usb_tx_en=1 clears the quiet count.
REQ-019 SHALL leave DRAIN for DETACH when the quiet count reaches TX_QUIET_CYCLES.
REQ-020 SHALL leave DRAIN for DETACH when the DRAIN dwell reaches DRAIN_TIMEOUT cycles.
REQ-021 SHALL, when both DRAIN exit conditions occur on the same cycle, make a single transition to DETACH.
REQ-022 SHALL drive usb_pullup_en=1 in IDLE and DRAIN and 0 in DETACH, ARM and BOOT; the pull-up is never re-enabled without reset.
REQ-023 SHALL remain in DETACH for exactly DETACH_CYCLES cycles, then go to ARM.
REQ-024 SHALL drive wb_s1/wb_s0 from the captured image_sel from entry to ARM onward, and 0 before ARM.
REQ-025 SHALL remain in ARM for exactly SETUP_CYCLES cycles, then go to BOOT.
REQ-026 SHALL drive wb_boot=1 in BOOT only; it stays high until reset.
REQ-027 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-028 SHALL use one shared 20-bit dwell counter, cleared on every state entry and saturating at all-ones.
REQ-029 SHALL use a separate 8-bit quiet counter that saturates.
REQ-030 SHALL require parameters in range 1..2^20-1, and TX_QUIET_CYCLES in range 1..255.
REQ-031 SHALL make the boot request-to-wb_boot latency exactly 1 + D + DETACH_CYCLES + SETUP_CYCLES cycles, where D is the DRAIN dwell.

Reset
REQ-032 SHALL, on reset_n=0 at a clock edge, set: state=IDLE, usb_pullup_en=1, wb_s1=0, wb_s0=0, wb_boot=0, busy=0, counters=0, captured image=0.
REQ-033 SHALL apply reset in any state, including mid-DETACH and BOOT, with the following cycle behaving as IDLE.

Structure
REQ-034 SHALL place the state encoding and the default timing constants in shared package usb_boot_pkg.
REQ-035 SHALL be a single module with no sub-modules; the counters are inline.

Verification
REQ-036 SHALL cover the nominal path: TX_QUIET=4, DETACH=20, SETUP=3; boot_req pulse at cycle 10 with usb_tx_en=0 and image_sel=2'b10 -> DRAIN at 11, pull-up low at 15, wb_s1=1/wb_s0=0 at 35, wb_boot=1 at 38.
REQ-037 SHALL cover busy-bus drain: usb_tx_en toggling every 3 cycles with TX_QUIET=4 and DRAIN_TIMEOUT=50 -> DETACH entered exactly 50 cycles after DRAIN entry.
REQ-038 SHALL cover image capture: image_sel=1 at the request, changed to 3 during DETACH -> wb_s1=0/wb_s0=1 when ARM is reached.
REQ-039 SHALL cover no abort: boot_req dropped 2 cycles after the request -> sequence completes and wb_boot=1.
REQ-040 SHALL cover reset mid-DETACH: reset_n=0 for 1 cycle -> next cycle usb_pullup_en=1, busy=0, wb_boot=0; a new request restarts with full timing.
REQ-041 SHALL cover the simultaneous-exit case: quiet count and timeout reaching their limits on the same cycle -> exactly one DETACH entry with the dwell counter at 0.
